// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin sharing of one I2C master core among up to four requesters
// A per-grant watchdog reclaims the core from a requester that holds it idle.
module i2c_master_arbiter #(
  parameter int NumReq       = 2,
  parameter int TimeoutWidth = 16
) (
  input  logic                    Clk_i,
  input  logic                    Reset_i,
  input  logic [NumReq-1:0]       Req_i,
  output logic [NumReq-1:0]       Grant_o,
  input  logic [NumReq-1:0]       ReqReceiveSend_n_i,
  input  logic [8*NumReq-1:0]     ReqReadCount_i,
  input  logic [NumReq-1:0]       ReqStartProcess_i,
  input  logic [NumReq-1:0]       ReqFIFOReadNext_i,
  input  logic [NumReq-1:0]       ReqFIFOWrite_i,
  input  logic [8*NumReq-1:0]     ReqData_i,
  output logic [NumReq-1:0]       ReqBusy_o,
  output logic [NumReq-1:0]       ReqError_o,
  output logic                    I2C_ReceiveSend_n_o,
  output logic                    I2C_StartProcess_o,
  output logic                    I2C_FIFOReadNext_o,
  output logic                    I2C_FIFOWrite_o,
  output logic [7:0]              I2C_ReadCount_o,
  output logic [7:0]              I2C_Data_o,
  input  logic                    I2C_Busy_i,
  input  logic                    I2C_Error_i,
  input  logic [TimeoutWidth-1:0] TimeoutPreset_i,
  output logic                    Timeout_o
);

  localparam int IdxW = (NumReq > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANTED,
    ST_DRAIN,
    ST_HOLDOFF
  } state_t;

  state_t                  state, state_n;
  logic [NumReq-1:0]       grant, grant_n;
  logic [NumReq-1:0]       blocked, blocked_n, blocked_set;
  logic [NumReq-1:0]       eligible;
  logic [IdxW-1:0]         last_grant, last_grant_n, sel_idx;
  logic                    sel_valid;
  logic [TimeoutWidth-1:0] wdog, wdog_n;
  logic                    timeout, timeout_n;
  logic                    granted, strobe_en;
  int                      cand;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state      <= ST_IDLE;
      grant      <= '0;
      blocked    <= '0;
      last_grant <= IdxW'(NumReq - 1);
      wdog       <= '0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      blocked    <= blocked_n;
      last_grant <= last_grant_n;
      wdog       <= wdog_n;
      timeout    <= timeout_n;
    end
  end

  // Round-robin pick: scan downward so the nearest requester after last_grant wins.
  always_comb begin
    eligible  = Req_i & ~blocked;
    sel_valid = 1'b0;
    sel_idx   = last_grant;
    cand      = 0;
    for (int i = NumReq; i >= 1; i--) begin
      cand = (int'(last_grant) + i) % NumReq;
      if (eligible[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    wdog_n       = wdog;
    timeout_n    = 1'b0;
    blocked_set  = '0;
    case (state)
      ST_IDLE, ST_HOLDOFF: begin
        if (sel_valid) begin
          grant_n      = {{(NumReq-1){1'b0}}, 1'b1} << sel_idx;
          last_grant_n = sel_idx;
          wdog_n       = TimeoutPreset_i;
          state_n      = ST_GRANTED;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GRANTED: begin
        // A voluntary release takes precedence over a coincident watchdog expiry.
        if (!Req_i[last_grant]) begin
          if (I2C_Busy_i) begin
            state_n = ST_DRAIN;
          end else begin
            grant_n = '0;
            state_n = ST_HOLDOFF;
          end
        end else if (I2C_Busy_i || ReqStartProcess_i[last_grant]) begin
          wdog_n = TimeoutPreset_i;
        end else if (wdog != '0) begin
          wdog_n = wdog - TimeoutWidth'(1);
          if (wdog == TimeoutWidth'(1) && TimeoutPreset_i != '0) begin
            timeout_n               = 1'b1;
            blocked_set[last_grant] = 1'b1;
            grant_n                 = '0;
            state_n                 = ST_HOLDOFF;
          end
        end
      end
      ST_DRAIN: begin
        if (!I2C_Busy_i) begin
          grant_n = '0;
          state_n = ST_HOLDOFF;
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
    endcase
    // A blocked requester must drop its request for a cycle before it is eligible again.
    blocked_n = (blocked & Req_i) | blocked_set;
  end

  assign granted   = |grant;
  assign strobe_en = granted && (state == ST_GRANTED);

  assign Grant_o   = grant;
  assign Timeout_o = timeout;

  assign I2C_ReceiveSend_n_o = granted   & ReqReceiveSend_n_i[last_grant];
  assign I2C_StartProcess_o  = strobe_en & ReqStartProcess_i[last_grant];
  assign I2C_FIFOReadNext_o  = strobe_en & ReqFIFOReadNext_i[last_grant];
  assign I2C_FIFOWrite_o     = strobe_en & ReqFIFOWrite_i[last_grant];
  assign I2C_ReadCount_o     = granted ? ReqReadCount_i[{last_grant, 3'b000} +: 8] : 8'h00;
  assign I2C_Data_o          = granted ? ReqData_i[{last_grant, 3'b000} +: 8] : 8'h00;

  assign ReqBusy_o  = ~grant | (grant & {NumReq{I2C_Busy_i}});
  assign ReqError_o = grant & {NumReq{I2C_Error_i}};

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - randomized and directed bench for i2c_master_arbiter against a behavioural model
module tb_i2c_master_arbiter;
  localparam int NR = 4;
  localparam int TW = 16;

  localparam int PH_IDLE    = 0;
  localparam int PH_OWNED   = 1;
  localparam int PH_DRAIN   = 2;
  localparam int PH_HOLDOFF = 3;

  logic            Clk_i = 1'b0;
  logic            Reset_i;
  logic [NR-1:0]   Req_i;
  logic [NR-1:0]   Grant_o;
  logic [NR-1:0]   ReqReceiveSend_n_i;
  logic [8*NR-1:0] ReqReadCount_i;
  logic [NR-1:0]   ReqStartProcess_i;
  logic [NR-1:0]   ReqFIFOReadNext_i;
  logic [NR-1:0]   ReqFIFOWrite_i;
  logic [8*NR-1:0] ReqData_i;
  logic [NR-1:0]   ReqBusy_o;
  logic [NR-1:0]   ReqError_o;
  logic            I2C_ReceiveSend_n_o, I2C_StartProcess_o, I2C_FIFOReadNext_o, I2C_FIFOWrite_o;
  logic [7:0]      I2C_ReadCount_o, I2C_Data_o;
  logic            I2C_Busy_i, I2C_Error_i;
  logic [TW-1:0]   TimeoutPreset_i;
  logic            Timeout_o;

  i2c_master_arbiter #(.NumReq(NR), .TimeoutWidth(TW)) dut (
    .Clk_i(Clk_i), .Reset_i(Reset_i), .Req_i(Req_i), .Grant_o(Grant_o),
    .ReqReceiveSend_n_i(ReqReceiveSend_n_i), .ReqReadCount_i(ReqReadCount_i),
    .ReqStartProcess_i(ReqStartProcess_i), .ReqFIFOReadNext_i(ReqFIFOReadNext_i),
    .ReqFIFOWrite_i(ReqFIFOWrite_i), .ReqData_i(ReqData_i),
    .ReqBusy_o(ReqBusy_o), .ReqError_o(ReqError_o),
    .I2C_ReceiveSend_n_o(I2C_ReceiveSend_n_o), .I2C_StartProcess_o(I2C_StartProcess_o),
    .I2C_FIFOReadNext_o(I2C_FIFOReadNext_o), .I2C_FIFOWrite_o(I2C_FIFOWrite_o),
    .I2C_ReadCount_o(I2C_ReadCount_o), .I2C_Data_o(I2C_Data_o),
    .I2C_Busy_i(I2C_Busy_i), .I2C_Error_i(I2C_Error_i),
    .TimeoutPreset_i(TimeoutPreset_i), .Timeout_o(Timeout_o)
  );

  always #5 Clk_i = ~Clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: who owns the core, what phase the ownership is in, and the idle countdown.
  bit          m_valid = 0;
  int          m_owner, m_phase, m_last, m_cnt, m_pick, m_c;
  bit          m_tout;
  bit [NR-1:0] m_blk;

  always @(posedge Clk_i) begin
    if (Reset_i) begin
      m_valid = 1;
      m_owner = -1;
      m_phase = PH_IDLE;
      m_last  = NR - 1;
      m_blk   = '0;
      m_cnt   = 0;
      m_tout  = 0;
    end else if (m_valid) begin
      m_tout = 0;
      m_blk  = m_blk & Req_i;
      if (m_phase == PH_IDLE || m_phase == PH_HOLDOFF) begin
        m_pick = -1;
        for (int k = 1; k <= NR && m_pick < 0; k++) begin
          m_c = (m_last + k) % NR;
          if (Req_i[m_c] && !m_blk[m_c]) m_pick = m_c;
        end
        if (m_pick >= 0) begin
          m_owner = m_pick;
          m_last  = m_pick;
          m_cnt   = int'(TimeoutPreset_i);
          m_phase = PH_OWNED;
        end else begin
          m_phase = PH_IDLE;
        end
      end else if (m_phase == PH_OWNED) begin
        if (!Req_i[m_owner]) begin
          if (I2C_Busy_i) m_phase = PH_DRAIN;
          else begin m_owner = -1; m_phase = PH_HOLDOFF; end
        end else if (I2C_Busy_i || ReqStartProcess_i[m_owner]) begin
          m_cnt = int'(TimeoutPreset_i);
        end else if (m_cnt > 0) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0 && TimeoutPreset_i != 0) begin
            m_tout         = 1;
            m_blk[m_owner] = 1'b1;
            m_owner        = -1;
            m_phase        = PH_HOLDOFF;
          end
        end
      end else begin
        if (!I2C_Busy_i) begin m_owner = -1; m_phase = PH_HOLDOFF; end
      end
    end
  end

  logic [NR-1:0] e_grant, e_busy, e_err;
  logic          e_rs, e_sp, e_rn, e_fw;
  logic [7:0]    e_rc, e_dt;
  int            o;
  bit            has;

  always @(negedge Clk_i) begin
    if (m_valid) begin
      has = (m_owner >= 0);
      o   = has ? m_owner : 0;
      for (int k = 0; k < NR; k++) begin
        e_grant[k] = has && (k == m_owner);
        e_busy[k]  = (has && k == m_owner) ? I2C_Busy_i : 1'b1;
        e_err[k]   = (has && k == m_owner) ? I2C_Error_i : 1'b0;
      end
      e_rs = has && ReqReceiveSend_n_i[o];
      e_sp = has && m_phase == PH_OWNED && ReqStartProcess_i[o];
      e_rn = has && m_phase == PH_OWNED && ReqFIFOReadNext_i[o];
      e_fw = has && m_phase == PH_OWNED && ReqFIFOWrite_i[o];
      e_rc = has ? ReqReadCount_i[o*8 +: 8] : 8'h00;
      e_dt = has ? ReqData_i[o*8 +: 8] : 8'h00;
      chk("model_grant",   32'(Grant_o),   32'(e_grant));
      chk("model_timeout", 32'(Timeout_o), 32'(m_tout));
      chk("model_strobes", 32'({I2C_ReceiveSend_n_o, I2C_StartProcess_o, I2C_FIFOReadNext_o, I2C_FIFOWrite_o}),
          32'({e_rs, e_sp, e_rn, e_fw}));
      chk("model_bytes",   32'({I2C_ReadCount_o, I2C_Data_o}), 32'({e_rc, e_dt}));
      chk("model_busy",    32'(ReqBusy_o),  32'(e_busy));
      chk("model_error",   32'(ReqError_o), 32'(e_err));
    end
  end

  task automatic cyc();
    @(posedge Clk_i);
    #1;
  endtask

  initial begin
    Reset_i = 1; Req_i = '0; ReqReceiveSend_n_i = '0; ReqReadCount_i = '0;
    ReqStartProcess_i = '0; ReqFIFOReadNext_i = '0; ReqFIFOWrite_i = '0; ReqData_i = '0;
    I2C_Busy_i = 0; I2C_Error_i = 0; TimeoutPreset_i = '0;
    cyc(); cyc();
    Reset_i = 0;
    chk("reset_grant", 32'(Grant_o), 32'h0);
    chk("reset_busy", 32'(ReqBusy_o), 32'hF);
    chk("reset_timeout", 32'(Timeout_o), 32'h0);

    Req_i = 4'b0011; cyc();
    chk("first_grant", 32'(Grant_o), 32'h1);
    Req_i = 4'b0010; cyc();
    chk("holdoff_grant", 32'(Grant_o), 32'h0);
    cyc();
    chk("second_grant", 32'(Grant_o), 32'h2);
    Req_i = 4'b0011; cyc(); cyc();
    chk("no_preempt", 32'(Grant_o), 32'h2);

    ReqData_i = 32'h0000_9100; ReqReadCount_i = 32'h0000_0200; ReqStartProcess_i = 4'b0001; #1;
    chk("other_start_ignored", 32'(I2C_StartProcess_o), 32'h0);
    chk("route_data", 32'(I2C_Data_o), 32'h91);
    chk("route_count", 32'(I2C_ReadCount_o), 32'h2);
    chk("busy_view", 32'(ReqBusy_o), 32'hD);
    cyc();
    ReqStartProcess_i = 4'b0010; #1;
    chk("start_pass", 32'(I2C_StartProcess_o), 32'h1);
    cyc();

    I2C_Busy_i = 1; Req_i = 4'b0001; ReqStartProcess_i = 4'b0010; ReqFIFOWrite_i = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("drain_grant", 32'(Grant_o), 32'h2);
      chk("drain_strobes", 32'({I2C_StartProcess_o, I2C_FIFOWrite_o}), 32'h0);
    end
    I2C_Busy_i = 0; ReqStartProcess_i = '0; ReqFIFOWrite_i = '0; cyc();
    chk("drain_release", 32'(Grant_o), 32'h0);
    cyc();
    chk("after_drain_grant", 32'(Grant_o), 32'h1);

    Req_i = '0; cyc(); cyc();
    TimeoutPreset_i = 16'd4; Req_i = 4'b0001; cyc();
    chk("wd_grant", 32'(Grant_o), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wd_hold", 32'({Grant_o, Timeout_o}), 32'h2);
    end
    cyc();
    chk("wd_fire", 32'({Grant_o, Timeout_o}), 32'h1);
    cyc();
    chk("wd_pulse_end", 32'({Grant_o, Timeout_o}), 32'h0);
    cyc();
    chk("wd_blocked", 32'(Grant_o), 32'h0);
    Req_i = '0; cyc();
    TimeoutPreset_i = '0; Req_i = 4'b0001; cyc();
    chk("wd_regrant", 32'(Grant_o), 32'h1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("wd_disabled", 32'({Grant_o, Timeout_o}), 32'h2);
    end

    Req_i = 4'b0011; ReqStartProcess_i = 4'b0001; #1;
    chk("pre_reset_start", 32'(I2C_StartProcess_o), 32'h1);
    Reset_i = 1; cyc();
    chk("mid_reset_grant", 32'(Grant_o), 32'h0);
    chk("mid_reset_start", 32'(I2C_StartProcess_o), 32'h0);
    chk("mid_reset_busy", 32'(ReqBusy_o), 32'hF);
    Reset_i = 0; ReqStartProcess_i = '0; cyc();
    chk("post_reset_grant", 32'(Grant_o), 32'h1);

    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NR; k++)
        if ($urandom_range(0, 7) == 0) Req_i[k] = ~Req_i[k];
      if ($urandom_range(0, 3) == 0) I2C_Busy_i = ~I2C_Busy_i;
      I2C_Error_i        = ($urandom_range(0, 7) == 0);
      ReqStartProcess_i  = NR'($urandom) & NR'($urandom) & NR'($urandom);
      ReqFIFOWrite_i     = NR'($urandom);
      ReqFIFOReadNext_i  = NR'($urandom);
      ReqReceiveSend_n_i = NR'($urandom);
      ReqReadCount_i     = $urandom;
      ReqData_i          = $urandom;
      if ($urandom_range(0, 63) == 0) TimeoutPreset_i = TW'($urandom_range(0, 8));
      Reset_i = ($urandom_range(0, 399) == 0);
      cyc();
    end

    Reset_i = 0;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
